mult_share_ctrl: RTL

Round-robin scheduler that shares one sequential shift-add multiplier (the team's N-bit multiplier) among NREQ requesters. It accepts one operand pair at a time and sequences the multiplier's load/run/finish protocol. It then returns the 2N-bit product to the granted requester, tagged with the requester's index. It sits between client blocks and the multiplier instance; the multiplier's ports connect directly to the mul_* ports below.

---
 rtl/mult_share_pkg.sv | 19 +
 rtl/mult_share_ctrl_rr_arbiter.sv | 33 +++
 rtl/mult_share_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/mult_share_pkg.sv
// rtl/mult_share_pkg.sv - shared types and defaults for the multiplier-sharing controller
package mult_share_pkg;

  localparam int N_DEF    = 8;
  localparam int NREQ_DEF = 4;
  localparam int TO_DEF   = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  function automatic int calc_idw(input int nreq);
    return (nreq > 1) ? $clog2(nreq) : 1;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// rtl/mult_share_ctrl_rr_arbiter.sv - combinational round-robin pick starting after last_grant
module rr_arbiter
  import mult_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = calc_idw(NREQ)
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_last_grant,
  output logic [NREQ-1:0] o_winner,
  output logic [IDW-1:0]  o_winner_idx,
  output logic            o_any
);

  logic [IDW-1:0] w_pos;

  // Walk the ring from last_grant+1; the first set request wins.
  always_comb begin
    o_winner     = '0;
    o_winner_idx = '0;
    o_any        = 1'b0;
    w_pos        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      w_pos = IDW'((int'(i_last_grant) + k) % NREQ);
      if (!o_any && i_req[w_pos]) begin
        o_any           = 1'b1;
        o_winner[w_pos] = 1'b1;
        o_winner_idx    = w_pos;
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// rtl/mult_share_ctrl.sv - round-robin scheduler sharing one sequential multiplier
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int NREQ  = NREQ_DEF,
  parameter int TO    = TO_DEF,
  localparam int IDW  = calc_idw(NREQ)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic              resp_valid,
  output logic [IDW-1:0]    resp_id,
  output logic [2*N-1:0]    resp_data,
  output logic              resp_err,
  output logic              busy,
  output logic [N-1:0]      mul_a,
  output logic [N-1:0]      mul_b,
  output logic              mul_start,
  input  logic              mul_finish,
  input  logic [2*N-1:0]    mul_out
);

  localparam int CW = (TO > 1) ? $clog2(TO) : 1;

  state_e         r_state, w_state_nx;
  logic [NREQ-1:0] r_gnt, w_gnt_nx;
  logic [IDW-1:0] r_gnt_idx, w_gnt_idx_nx;
  logic [IDW-1:0] r_last, w_last_nx;
  logic [IDW-1:0] r_resp_id, w_resp_id_nx;
  logic [N-1:0]   r_mul_a, w_mul_a_nx;
  logic [N-1:0]   r_mul_b, w_mul_b_nx;
  logic           r_mul_start, w_mul_start_nx;
  logic           r_resp_valid, w_resp_valid_nx;
  logic           r_resp_err, w_resp_err_nx;
  logic [2*N-1:0] r_resp_data, w_resp_data_nx;
  logic [CW-1:0]  r_cnt, w_cnt_nx;
  logic           r_busy;
  logic           w_arb_en;

  logic [NREQ-1:0] w_win;
  logic [IDW-1:0]  w_win_idx;
  logic            w_any;

  logic [N-1:0] w_a_arr [NREQ];
  logic [N-1:0] w_b_arr [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_a_arr[g] = req_a[g*N +: N];
    assign w_b_arr[g] = req_b[g*N +: N];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .i_req        (req),
    .i_last_grant (r_last),
    .o_winner     (w_win),
    .o_winner_idx (w_win_idx),
    .o_any        (w_any)
  );

  // Arbitration runs in IDLE and again in DONE so back-to-back operations
  // lose no cycle; the grant pulse itself is spent in IDLE while operands latch.
  always_comb begin
    w_state_nx      = r_state;
    w_gnt_nx        = '0;
    w_gnt_idx_nx    = r_gnt_idx;
    w_last_nx       = r_last;
    w_resp_id_nx    = r_resp_id;
    w_mul_a_nx      = r_mul_a;
    w_mul_b_nx      = r_mul_b;
    w_mul_start_nx  = 1'b0;
    w_resp_valid_nx = 1'b0;
    w_resp_err_nx   = r_resp_err;
    w_resp_data_nx  = r_resp_data;
    w_cnt_nx        = r_cnt;
    w_arb_en        = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (|r_gnt) begin
          w_mul_a_nx = w_a_arr[r_gnt_idx];
          w_mul_b_nx = w_b_arr[r_gnt_idx];
          w_state_nx = S_LOAD;
        end else begin
          w_arb_en = 1'b1;
        end
      end
      S_LOAD: begin
        w_mul_start_nx = 1'b1;
        w_cnt_nx       = '0;
        w_state_nx     = S_RUN;
      end
      S_RUN: begin
        w_mul_start_nx = 1'b1;
        if (mul_finish) begin
          w_mul_start_nx  = 1'b0;
          w_resp_valid_nx = 1'b1;
          w_resp_data_nx  = mul_out;
          w_resp_err_nx   = 1'b0;
          w_resp_id_nx    = r_gnt_idx;
          w_state_nx      = S_DONE;
        end else if (r_cnt == CW'(TO - 1)) begin
          w_mul_start_nx  = 1'b0;
          w_resp_valid_nx = 1'b1;
          w_resp_data_nx  = '0;
          w_resp_err_nx   = 1'b1;
          w_resp_id_nx    = r_gnt_idx;
          w_state_nx      = S_DONE;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_arb_en   = 1'b1;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase

    if (w_arb_en && w_any) begin
      w_gnt_nx     = w_win;
      w_gnt_idx_nx = w_win_idx;
      w_last_nx    = w_win_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_gnt_idx    <= '0;
      r_last       <= IDW'(NREQ - 1);
      r_resp_id    <= '0;
      r_mul_a      <= '0;
      r_mul_b      <= '0;
      r_mul_start  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_data  <= '0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_gnt        <= w_gnt_nx;
      r_gnt_idx    <= w_gnt_idx_nx;
      r_last       <= w_last_nx;
      r_resp_id    <= w_resp_id_nx;
      r_mul_a      <= w_mul_a_nx;
      r_mul_b      <= w_mul_b_nx;
      r_mul_start  <= w_mul_start_nx;
      r_resp_valid <= w_resp_valid_nx;
      r_resp_err   <= w_resp_err_nx;
      r_resp_data  <= w_resp_data_nx;
      r_cnt        <= w_cnt_nx;
      r_busy       <= (w_state_nx != S_IDLE);
    end
  end

  assign gnt        = r_gnt;
  assign resp_valid = r_resp_valid;
  assign resp_id    = r_resp_id;
  assign resp_data  = r_resp_data;
  assign resp_err   = r_resp_err;
  assign busy       = r_busy;
  assign mul_a      = r_mul_a;
  assign mul_b      = r_mul_b;
  assign mul_start  = r_mul_start;

endmodule
